// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam int SHIFT_OP_W = 3;

  // Shift/rotate modes; encodings 5..7 are reserved and pass data through.
  typedef enum logic [SHIFT_OP_W-1:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_t;

  // Number of power-of-two shift levels needed to cover a WIDTH-bit operand.
  function automatic int shift_levels(input int width);
    return $clog2(width);
  endfunction

  // Number of register stages when levels are grouped PER to a stage.
  function automatic int shift_groups(input int width, input int per);
    return (shift_levels(width) + per - 1) / per;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: shifts or rotates by DIST when enabled.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  en_i,
  input  logic [SHIFT_OP_W-1:0] op_i,
  input  logic                  sign_i,
  output logic [WIDTH-1:0]      data_o
);

  // Right shifts are done directly; SRA fills with the operand's original MSB,
  // which is carried down the pipe rather than re-read from the shifted data.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        SHIFT_SLL: data_o = {data_i[WIDTH-1-DIST:0], {DIST{1'b0}}};
        SHIFT_SRL: data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        SHIFT_SRA: data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        SHIFT_ROL: data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
        SHIFT_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        default:   data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter stream element with a global-stall valid/ready
// handshake and an opaque tag travelling alongside each operand.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [SHIFT_OP_W-1:0]         op_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] shamt_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic [TAG_WIDTH-1:0]          tag_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [TAG_WIDTH-1:0]          tag_o
);

  localparam int L  = shift_levels(DATA_WIDTH);
  localparam int G  = shift_groups(DATA_WIDTH, PIPE_EVERY);
  localparam int SW = $clog2(DATA_WIDTH);

  // Stage sources: stage 0 reads the input port, stage g reads register g-1.
  logic [DATA_WIDTH-1:0] src_data  [G];
  logic [SW-1:0]         src_shamt [G];
  logic [SHIFT_OP_W-1:0] src_op    [G];
  logic                  src_sign  [G];
  logic [TAG_WIDTH-1:0]  src_tag   [G];
  logic                  src_valid [G];

  // Data after the last level of each group, i.e. the next value of that stage.
  logic [DATA_WIDTH-1:0] data_d    [G];
  logic [DATA_WIDTH-1:0] lvl_out   [L];

  logic [DATA_WIDTH-1:0] data_q    [G];
  logic [SW-1:0]         shamt_q   [G];
  logic [SHIFT_OP_W-1:0] op_q      [G];
  logic                  sign_q    [G];
  logic [TAG_WIDTH-1:0]  tag_q     [G];
  logic                  valid_q   [G];

  logic stall;

  // A held result blocks the whole pipe, bubbles included.
  assign stall      = out_valid_o && !out_ready_i;
  assign in_ready_o = !stall;

  for (genvar g = 0; g < G; g++) begin : gen_stage
    localparam int LAST = (((g + 1) * PIPE_EVERY < L) ? (g + 1) * PIPE_EVERY : L) - 1;

    if (g == 0) begin : gen_head
      assign src_data[g]  = data_i;
      assign src_shamt[g] = shamt_i;
      assign src_op[g]    = op_i;
      assign src_sign[g]  = data_i[DATA_WIDTH-1];
      assign src_tag[g]   = tag_i;
      assign src_valid[g] = in_valid_i;
    end else begin : gen_body
      assign src_data[g]  = data_q[g-1];
      assign src_shamt[g] = shamt_q[g-1];
      assign src_op[g]    = op_q[g-1];
      assign src_sign[g]  = sign_q[g-1];
      assign src_tag[g]   = tag_q[g-1];
      assign src_valid[g] = valid_q[g-1];
    end

    assign data_d[g] = lvl_out[LAST];
  end

  for (genvar k = 0; k < L; k++) begin : gen_level
    localparam int GRP = k / PIPE_EVERY;
    logic [DATA_WIDTH-1:0] lvl_in;

    if (k % PIPE_EVERY == 0) begin : gen_first
      assign lvl_in = src_data[GRP];
    end else begin : gen_chain
      assign lvl_in = lvl_out[k-1];
    end

    shift_level #(
      .WIDTH (DATA_WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .data_i (lvl_in),
      .en_i   (src_shamt[GRP][k]),
      .op_i   (src_op[GRP]),
      .sign_i (src_sign[GRP]),
      .data_o (lvl_out[k])
    );
  end

  // Pipeline registers: clear on reset, hold on stall, otherwise advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int g = 0; g < G; g++) begin
        data_q[g]  <= '0;
        shamt_q[g] <= '0;
        op_q[g]    <= '0;
        sign_q[g]  <= 1'b0;
        tag_q[g]   <= '0;
        valid_q[g] <= 1'b0;
      end
    end else if (!stall) begin
      for (int g = 0; g < G; g++) begin
        data_q[g]  <= data_d[g];
        shamt_q[g] <= src_shamt[g];
        op_q[g]    <= src_op[g];
        sign_q[g]  <= src_sign[g];
        tag_q[g]   <= src_tag[g];
        valid_q[g] <= src_valid[g];
      end
    end
  end

  assign out_valid_o = valid_q[G-1];
  assign data_o      = data_q[G-1];
  assign tag_o       = tag_q[G-1];

  // The final stage's control fields have no consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[G-1], op_q[G-1], sign_q[G-1]};

endmodule
